// File: rtl/audioport_pkg.sv
// Shared types and sizing for the audioport sample path.
package audioport_pkg;

    localparam int AUDIO_FIFO_SIZE = 16;
    localparam int AUDIO_DATA_W    = 24;

    typedef enum logic {STANDBY, PLAY} play_state_t;

    // Fill level must represent 0..size inclusive.
    function automatic int fill_width(input int size);
        return $clog2(size) + 1;
    endfunction

    localparam int AUDIO_FILL_W = fill_width(AUDIO_FIFO_SIZE);

endpackage

// File: rtl/audio_fifo_scheduler_sample_fifo.sv
// Single circular sample FIFO; a looped bit separates full from empty when head == tail.
module sample_fifo
    import audioport_pkg::*;
#(
    parameter int SIZE   = AUDIO_FIFO_SIZE,
    parameter int DATA_W = AUDIO_DATA_W,
    localparam int PTR_W  = $clog2(SIZE),
    localparam int FILL_W = fill_width(SIZE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              empty,
    output logic              full,
    output logic [FILL_W-1:0] fill
);

    logic [DATA_W-1:0] mem [SIZE];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [PTR_W-1:0]  diff;
    logic              looped;
    logic              do_push;
    logic              do_pop;
    logic              head_wrap;
    logic              tail_wrap;

    assign empty     = (head == tail) && !looped;
    assign full      = (head == tail) && looped;
    assign diff      = head - tail;
    assign fill      = full ? FILL_W'(SIZE) : {1'b0, diff};
    assign rd_data   = mem[tail];
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_wrap = do_push && (head == PTR_W'(SIZE - 1));
    assign tail_wrap = do_pop && (tail == PTR_W'(SIZE - 1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            head   <= '0;
            tail   <= '0;
            looped <= 1'b0;
        end else begin
            if (do_push) head <= head + PTR_W'(1);
            if (do_pop)  tail <= tail + PTR_W'(1);
            // Head wrapping arms the full/empty tie-break, tail wrapping disarms it.
            if (head_wrap ^ tail_wrap) looped <= !looped;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clr) mem[head] <= wr_data;
    end

endmodule

// File: rtl/audio_fifo_scheduler.sv
// Stereo sample buffer and playback sequencer feeding the DSP filter input.
module audio_fifo_scheduler
    import audioport_pkg::*;
#(
    parameter int FIFO_SIZE = AUDIO_FIFO_SIZE,
    parameter int DATA_W    = AUDIO_DATA_W,
    localparam int FILL_W   = fill_width(FIFO_SIZE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_in,
    input  logic              stop_in,
    input  logic              clr_in,
    input  logic              irqack_in,
    input  logic              wr_in,
    input  logic              wr_chan_in,
    input  logic [DATA_W-1:0] wr_data_in,
    input  logic              req_in,
    output logic [DATA_W-1:0] audio0_out,
    output logic [DATA_W-1:0] audio1_out,
    output logic              tick_out,
    output logic              play_out,
    output logic              irq_out,
    output logic              wr_err_out,
    output logic [FILL_W-1:0] lfill_out,
    output logic [FILL_W-1:0] rfill_out
);

    play_state_t       state;
    play_state_t       next_state;
    logic              pop_en;
    logic              lpush;
    logic              rpush;
    logic              lempty, lfull, rempty, rfull;
    logic [DATA_W-1:0] ldata, rdata;
    logic              l_drained, r_drained;
    logic              irq_set;
    logic              wr_err_nxt;

    always_comb begin
        next_state = state;
        if (stop_in)       next_state = STANDBY;
        else if (start_in) next_state = PLAY;
    end

    always_comb begin
        pop_en     = req_in && (state == PLAY) && !clr_in;
        lpush      = wr_in && !wr_chan_in && !clr_in;
        rpush      = wr_in && wr_chan_in && !clr_in;
        // A channel ends up empty after a pop only if nothing lands in it this cycle.
        l_drained  = !(lpush && !lfull) && (lempty || (lfill_out == FILL_W'(1)));
        r_drained  = !(rpush && !rfull) && (rempty || (rfill_out == FILL_W'(1)));
        irq_set    = pop_en && l_drained && r_drained;
        wr_err_nxt = wr_in && !clr_in && (wr_chan_in ? rfull : lfull);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= STANDBY;
            audio0_out <= '0;
            audio1_out <= '0;
            tick_out   <= 1'b0;
            irq_out    <= 1'b0;
            wr_err_out <= 1'b0;
        end else begin
            state      <= next_state;
            tick_out   <= pop_en;
            wr_err_out <= wr_err_nxt;
            if (clr_in) begin
                audio0_out <= '0;
                audio1_out <= '0;
            end else if (pop_en) begin
                audio0_out <= lempty ? '0 : ldata;
                audio1_out <= rempty ? '0 : rdata;
            end
            if (clr_in || stop_in) irq_out <= 1'b0;
            else if (irq_set)      irq_out <= 1'b1;
            else if (irqack_in)    irq_out <= 1'b0;
        end
    end

    assign play_out = (state == PLAY);

    sample_fifo #(.SIZE(FIFO_SIZE), .DATA_W(DATA_W)) u_left (
        .clk(clk), .rst(rst), .clr(clr_in), .push(lpush), .pop(pop_en),
        .wr_data(wr_data_in), .rd_data(ldata), .empty(lempty), .full(lfull),
        .fill(lfill_out)
    );

    sample_fifo #(.SIZE(FIFO_SIZE), .DATA_W(DATA_W)) u_right (
        .clk(clk), .rst(rst), .clr(clr_in), .push(rpush), .pop(pop_en),
        .wr_data(wr_data_in), .rd_data(rdata), .empty(rempty), .full(rfull),
        .fill(rfill_out)
    );

endmodule

// File: tb/tb_audio_fifo_scheduler.sv
// Directed bench for audio_fifo_scheduler with a queue-based reference model.
module tb_audio_fifo_scheduler;

    localparam int SIZE = 16;
    localparam int DW   = 24;
    localparam int FW   = $clog2(SIZE) + 1;

    logic          clk = 1'b0;
    logic          rst, start_in, stop_in, clr_in, irqack_in;
    logic          wr_in, wr_chan_in, req_in;
    logic [DW-1:0] wr_data_in;
    logic [DW-1:0] audio0_out, audio1_out;
    logic          tick_out, play_out, irq_out, wr_err_out;
    logic [FW-1:0] lfill_out, rfill_out;

    int n_checks = 0;
    int n_fail   = 0;

    audio_fifo_scheduler #(.FIFO_SIZE(SIZE), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .start_in(start_in), .stop_in(stop_in),
        .clr_in(clr_in), .irqack_in(irqack_in), .wr_in(wr_in),
        .wr_chan_in(wr_chan_in), .wr_data_in(wr_data_in), .req_in(req_in),
        .audio0_out(audio0_out), .audio1_out(audio1_out), .tick_out(tick_out),
        .play_out(play_out), .irq_out(irq_out), .wr_err_out(wr_err_out),
        .lfill_out(lfill_out), .rfill_out(rfill_out)
    );

    always #5 clk = ~clk;

    // Reference model: two sample queues plus the expected registered outputs.
    logic [DW-1:0] lq[$];
    logic [DW-1:0] rq[$];
    logic [DW-1:0] m_a0, m_a1;
    bit            m_play, m_irq, m_tick, m_werr;
    bit            chk_en = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int  lsz, rsz;
        bit  pop, lfull, rfull, sel_full;
        if (rst) begin
            lq.delete(); rq.delete();
            m_a0 = '0; m_a1 = '0;
            m_play = 0; m_irq = 0; m_tick = 0; m_werr = 0;
            chk_en = 1;
            return;
        end
        if (clr_in) begin
            lq.delete(); rq.delete();
            m_a0 = '0; m_a1 = '0;
            m_irq = 0; m_tick = 0; m_werr = 0;
        end else begin
            lsz      = lq.size();
            rsz      = rq.size();
            pop      = req_in && m_play;
            lfull    = (lsz == SIZE);
            rfull    = (rsz == SIZE);
            sel_full = wr_chan_in ? rfull : lfull;
            m_tick   = pop;
            m_werr   = wr_in && sel_full;
            if (pop) begin
                if (lsz > 0) m_a0 = lq.pop_front(); else m_a0 = '0;
                if (rsz > 0) m_a1 = rq.pop_front(); else m_a1 = '0;
            end
            if (wr_in && !sel_full) begin
                if (wr_chan_in) rq.push_back(wr_data_in);
                else            lq.push_back(wr_data_in);
            end
            if (stop_in)                                        m_irq = 0;
            else if (pop && lq.size() == 0 && rq.size() == 0)   m_irq = 1;
            else if (irqack_in)                                 m_irq = 0;
        end
        if (stop_in)       m_play = 0;
        else if (start_in) m_play = 1;
    endtask

    always @(posedge clk) model_step();

    always @(negedge clk) begin
        if (chk_en) begin
            chk("audio0", audio0_out, m_a0);
            chk("audio1", audio1_out, m_a1);
            chk("tick", tick_out, m_tick);
            chk("play", play_out, m_play);
            chk("irq", irq_out, m_irq);
            chk("wr_err", wr_err_out, m_werr);
            chk("lfill", lfill_out, lq.size());
            chk("rfill", rfill_out, rq.size());
        end
    end

    task automatic drive(input bit st, input bit sp, input bit cl, input bit ack,
                         input bit w, input bit ch, input logic [DW-1:0] d, input bit rq_i);
        start_in = st; stop_in = sp; clr_in = cl; irqack_in = ack;
        wr_in = w; wr_chan_in = ch; wr_data_in = d; req_in = rq_i;
        @(negedge clk);
        start_in = 0; stop_in = 0; clr_in = 0; irqack_in = 0;
        wr_in = 0; wr_chan_in = 0; wr_data_in = '0; req_in = 0;
    endtask

    task automatic idle();             drive(0, 0, 0, 0, 0, 0, '0, 0); endtask
    task automatic wl(input logic [DW-1:0] d); drive(0, 0, 0, 0, 1, 0, d, 0); endtask
    task automatic wrr(input logic [DW-1:0] d); drive(0, 0, 0, 0, 1, 1, d, 0); endtask
    task automatic req();              drive(0, 0, 0, 0, 0, 0, '0, 1); endtask
    task automatic start();            drive(1, 0, 0, 0, 0, 0, '0, 0); endtask
    task automatic stop();             drive(0, 1, 0, 0, 0, 0, '0, 0); endtask
    task automatic ack();              drive(0, 0, 0, 1, 0, 0, '0, 0); endtask

    initial begin
        rst = 1; start_in = 0; stop_in = 0; clr_in = 0; irqack_in = 0;
        wr_in = 0; wr_chan_in = 0; wr_data_in = '0; req_in = 0;
        repeat (2) @(negedge clk);
        chk("rst_play", play_out, 0);
        chk("rst_audio0", audio0_out, 0);
        chk("rst_lfill", lfill_out, 0);
        rst = 0;

        // First stereo pair end to end.
        idle(); idle();
        wl(24'h000001); wrr(24'h0000A1); start();
        chk("start_play", play_out, 1);
        idle(); idle(); idle();
        req();
        chk("t1_audio0", audio0_out, 24'h000001);
        chk("t1_audio1", audio1_out, 24'h0000A1);
        chk("t1_tick", tick_out, 1);
        chk("t1_irq", irq_out, 1);
        chk("t1_model_a0", m_a0, 24'h000001);
        idle();
        chk("t1_tick_once", tick_out, 0);
        chk("t1_hold", audio0_out, 24'h000001);
        ack();
        chk("t1_ack", irq_out, 0);
        stop();
        chk("stop_play", play_out, 0);

        // Overfill left in STANDBY; the 17th sample must be dropped.
        for (int i = 0; i < 16; i++) wl(24'(i));
        chk("full_lfill", lfill_out, 16);
        wl(24'hBADBAD);
        chk("ovf_err", wr_err_out, 1);
        chk("ovf_lfill", lfill_out, 16);
        idle();
        chk("ovf_err_once", wr_err_out, 0);

        // Drain 16 pairs through the wrap point.
        for (int i = 0; i < 16; i++) wrr(24'h80 + 24'(i));
        start();
        for (int i = 0; i < 16; i++) begin
            req();
            chk("drain_a0", audio0_out, 24'(i));
            chk("drain_a1", audio1_out, 24'h80 + 24'(i));
            chk("drain_irq", irq_out, (i == 15) ? 1 : 0);
        end
        ack();
        chk("drain_ack", irq_out, 0);

        // Left-only data: right underruns to zero.
        wl(24'hA); wl(24'hB); wl(24'hC);
        req();
        chk("under_a0", audio0_out, 24'hA);
        chk("under_a1", audio1_out, 0);
        chk("under_tick", tick_out, 1);
        chk("under_rfill", rfill_out, 0);
        chk("under_irq", irq_out, 0);
        req(); req();
        chk("under_a0_last", audio0_out, 24'hC);
        chk("under_irq_set", irq_out, 1);

        // Clear beats a simultaneous write and request.
        for (int i = 0; i < 5; i++) begin
            wl(24'h20 + 24'(i));
            wrr(24'h30 + 24'(i));
        end
        chk("pre_clr_lfill", lfill_out, 5);
        chk("pre_clr_irq", irq_out, 1);
        drive(0, 0, 1, 0, 1, 0, 24'h77, 1);
        chk("clr_lfill", lfill_out, 0);
        chk("clr_rfill", rfill_out, 0);
        chk("clr_a0", audio0_out, 0);
        chk("clr_irq", irq_out, 0);
        chk("clr_tick", tick_out, 0);
        chk("clr_play", play_out, 1);

        // Reset mid-play with data buffered.
        for (int i = 0; i < 9; i++) begin
            wl(24'h40 + 24'(i));
            wrr(24'h50 + 24'(i));
        end
        req();
        chk("mid_a0", audio0_out, 24'h40);
        chk("mid_lfill", lfill_out, 8);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("rst_mid_play", play_out, 0);
        chk("rst_mid_lfill", lfill_out, 0);
        chk("rst_mid_a1", audio1_out, 0);
        req();
        chk("rst_mid_notick", tick_out, 0);

        // Write to a full FIFO is rejected even while a pop frees a slot.
        for (int i = 0; i < 16; i++) wl(24'h60 + 24'(i));
        start();
        drive(0, 0, 0, 0, 1, 0, 24'h99, 1);
        chk("wp_err", wr_err_out, 1);
        chk("wp_lfill", lfill_out, 15);
        chk("wp_a0", audio0_out, 24'h60);
        idle(); idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
